hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 35 +++
 rtl/hazard_scoreboard_sb_counter.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared processor constants for the decode-stage hazard scoreboard:
//   - NUM_REGS / REG_W : register file size and register-number width
//   - CNT_W            : width of each per-register pending-write countdown
//   - halt_state_t     : halt FSM encoding (RUN=0, DRAIN=1, HALTED=2)
//   - LAT_ALU/LAT_LOAD : countdown value loaded when a producer issues
// Optional feature macro: HAZARD_SCOREBOARD_FORWARD_EN
//   defined   -> EX/MEM forwarding exists: ALU results never stall (LAT_ALU=0),
//                a load stalls its consumer for one cycle (LAT_LOAD=1).
//   undefined -> no forwarding: every producer blocks until write-back (2).
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 3;
    localparam int CNT_W    = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    // The register file is write-before-read, so a producer issued at t is
    // readable by decode at t+3; two cycles of blocking cover t+1 and t+2.
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    localparam logic [CNT_W-1:0] LAT_ALU  = 2'd0;
    localparam logic [CNT_W-1:0] LAT_LOAD = 2'd1;
`else
    localparam logic [CNT_W-1:0] LAT_ALU  = 2'd2;
    localparam logic [CNT_W-1:0] LAT_LOAD = 2'd2;
`endif

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// One scoreboard entry: a countdown of cycles until the pending write to this
// register becomes visible to decode.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears the count)
//   load      : a producer for this register issues this cycle
//   load_val  : countdown value to load (producer latency)
//   busy      : count is nonzero, i.e. a write is still pending
// A load wins over the decrement in the same cycle, so a re-issue always
// restarts the full latency rather than releasing early.
// -----------------------------------------------------------------------------
module sb_counter
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Decode-stage RAW hazard detector and HALT drain controller for an in-order
// pipeline. Each register has a countdown of cycles until its pending write
// is visible; a decode instruction that reads a busy register stalls.
// Optional feature macro: HAZARD_SCOREBOARD_FORWARD_EN (selects latencies in
// hazard_scoreboard_pkg).
// Ports:
//   clk, rst                  : clock (rising edge), async active-high reset
//   id_valid, id_kill         : decode holds a live instruction (kill squashes)
//   id_readReg1/2, id_useReg1/2 : source registers and whether each is read
//   id_regWrite, id_writeRegSel : destination write enable / register
//   id_memRead                : instruction is a load (selects LAT_LOAD)
//   id_halt                   : instruction is HALT
//   stall                     : freeze PC and IF/ID, bubble into ID/EX
//   halted                    : pipeline drained after HALT (held until reset)
//   busy                      : bit r set while register r has a pending write
//   dbg_state                 : current halt FSM state, for observation
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic                id_kill,
    input  logic [REG_W-1:0]    id_readReg1,
    input  logic [REG_W-1:0]    id_readReg2,
    input  logic                id_useReg1,
    input  logic                id_useReg2,
    input  logic                id_regWrite,
    input  logic [REG_W-1:0]    id_writeRegSel,
    input  logic                id_memRead,
    input  logic                id_halt,
    output logic                stall,
    output logic                halted,
    output logic [NUM_REGS-1:0] busy,
    output halt_state_t         dbg_state
);

    halt_state_t         state_q, state_d;
    logic [1:0]          drain_q, drain_d;
    logic                halted_q, halted_d;

    logic                id_live;
    logic                raw_hazard;
    logic                stall_w;
    logic                issue;
    logic [CNT_W-1:0]    lat_sel;
    logic [NUM_REGS-1:0] load_vec;
    logic [NUM_REGS-1:0] busy_w;

    // Killed or invalid decode slots contribute neither stalls nor loads.
    assign id_live    = id_valid & ~id_kill;
    // Only entries already pending count: an instruction reading its own
    // destination does not see the load it is about to make.
    assign raw_hazard = (id_useReg1 & busy_w[id_readReg1]) |
                        (id_useReg2 & busy_w[id_readReg2]);
    assign stall_w    = (state_q != RUN) | (id_live & raw_hazard);
    assign issue      = id_live & ~stall_w & (state_q == RUN);
    assign lat_sel    = id_memRead ? LAT_LOAD : LAT_ALU;

    always_comb begin
        load_vec = '0;
        if (issue && id_regWrite) begin
            load_vec[id_writeRegSel] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
        sb_counter u_sb_counter (
            .clk      (clk),
            .rst      (rst),
            .load     (load_vec[gi]),
            .load_val (lat_sel),
            .busy     (busy_w[gi])
        );
    end

    // Halt FSM: after HALT issues, wait at least three cycles (drain counter)
    // and until no write is pending, then hold HALTED until reset.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (issue && id_halt) begin
                    state_d = DRAIN;
                    drain_d = 2'd3;
                end
            end
            DRAIN: begin
                if (drain_q != 2'd0) begin
                    drain_d = drain_q - 2'd1;
                end
                // A counter that already expired keeps waiting on busy alone.
                if ((drain_q == 2'd1 || drain_q == 2'd0) && busy_w == '0) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            drain_q  <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
        end
    end

    assign stall     = stall_w;
    assign halted    = halted_q;
    assign busy      = busy_w;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed testbench for hazard_scoreboard. Inputs change 1 time unit after
// the rising edge; outputs {dbg_state, stall, halted, busy} are sampled on the
// falling edge and compared to expectations queued when each step is driven.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_kill;
    logic [2:0] id_readReg1;
    logic [2:0] id_readReg2;
    logic       id_useReg1;
    logic       id_useReg2;
    logic       id_regWrite;
    logic [2:0] id_writeRegSel;
    logic       id_memRead;
    logic       id_halt;
    logic       stall;
    logic       halted;
    logic [7:0] busy;
    logic [1:0] dbg_state;

    logic [11:0] exp_q[$];
    int          n_checks;
    int          n_fail;

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    localparam logic [7:0] MID_DRAIN_BUSY = 8'h04;
`else
    localparam logic [7:0] MID_DRAIN_BUSY = 8'h06;
`endif

    hazard_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_kill        (id_kill),
        .id_readReg1    (id_readReg1),
        .id_readReg2    (id_readReg2),
        .id_useReg1     (id_useReg1),
        .id_useReg2     (id_useReg2),
        .id_regWrite    (id_regWrite),
        .id_writeRegSel (id_writeRegSel),
        .id_memRead     (id_memRead),
        .id_halt        (id_halt),
        .stall          (stall),
        .halted         (halted),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [11:0] ex(input logic [1:0] st, input logic s,
                                       input logic h, input logic [7:0] b);
        return {st, s, h, b};
    endfunction

    task automatic drive(input logic v, input logic k,
                         input logic [2:0] r1, input logic u1,
                         input logic [2:0] r2, input logic u2,
                         input logic wr, input logic [2:0] ws,
                         input logic mem, input logic hlt);
        id_valid       = v;
        id_kill        = k;
        id_readReg1    = r1;
        id_useReg1     = u1;
        id_readReg2    = r2;
        id_useReg2     = u2;
        id_regWrite    = wr;
        id_writeRegSel = ws;
        id_memRead     = mem;
        id_halt        = hlt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare(input string tag);
        logic [11:0] e;
        logic [11:0] obs;
        e   = exp_q.pop_front();
        obs = {dbg_state, stall, halted, busy};
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed state=%0d stall=%b halted=%b busy=%h, expected state=%0d stall=%b halted=%b busy=%h",
                   tag, obs[11:10], obs[9], obs[8], obs[7:0], e[11:10], e[9], e[8], e[7:0]);
        end
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic step(input logic [11:0] exp, input string tag);
        exp_q.push_back(exp);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        exp_q.push_back(ex(RUN, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        compare("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
        // Load-use: LD r2 then a reader of r2 stalls exactly one cycle.
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd2, 1, 0);
        step(ex(RUN, 0, 0, 8'h00), "ld_r2_issue");
        drive(1, 0, 3'd2, 1, 3'd0, 0, 1, 3'd3, 0, 0);
        step(ex(RUN, 1, 0, 8'h04), "ld_use_stall");
        step(ex(RUN, 0, 0, 8'h00), "ld_use_release");
        idle();
        step(ex(RUN, 0, 0, 8'h00), "alu_no_busy");
        // ALU producer: consumer is never stalled.
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0, 0);
        step(ex(RUN, 0, 0, 8'h00), "alu_r2_issue");
        drive(1, 0, 3'd2, 1, 3'd0, 0, 0, 3'd0, 0, 0);
        step(ex(RUN, 0, 0, 8'h00), "alu_use_no_stall");
        idle();
`else
        // RAW without forwarding: ADD r1 at t, reader at t+1 stalls t+1, t+2.
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd1, 0, 0);
        step(ex(RUN, 0, 0, 8'h00), "add_r1_issue");
        drive(1, 0, 3'd1, 1, 3'd0, 0, 1, 3'd5, 0, 0);
        step(ex(RUN, 1, 0, 8'h02), "raw_t1");
        step(ex(RUN, 1, 0, 8'h02), "raw_t2");
        step(ex(RUN, 0, 0, 8'h00), "raw_t3_release");
        idle();
        step(ex(RUN, 0, 0, 8'h20), "r5_busy_a");
        step(ex(RUN, 0, 0, 8'h20), "r5_busy_b");
        step(ex(RUN, 0, 0, 8'h00), "r5_clear");

        // Reading the own destination raises no hazard.
        drive(1, 0, 3'd6, 1, 3'd6, 1, 1, 3'd6, 0, 0);
        step(ex(RUN, 0, 0, 8'h00), "self_dest");
        idle();
        step(ex(RUN, 0, 0, 8'h40), "r6_busy_a");
        step(ex(RUN, 0, 0, 8'h40), "r6_busy_b");

        // Killed ADD r3 leaves r3 free; a reader is not stalled.
        drive(1, 1, 3'd0, 0, 3'd0, 0, 1, 3'd3, 0, 0);
        step(ex(RUN, 0, 0, 8'h00), "kill_r3");
        drive(1, 0, 3'd3, 1, 3'd3, 1, 0, 3'd0, 0, 0);
        step(ex(RUN, 0, 0, 8'h00), "read_r3_after_kill");

        // Killed or invalid readers of a busy register do not stall or load.
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd7, 0, 0);
        step(ex(RUN, 0, 0, 8'h00), "add_r7_issue");
        drive(1, 1, 3'd7, 1, 3'd7, 1, 0, 3'd0, 0, 0);
        step(ex(RUN, 0, 0, 8'h80), "killed_reader_no_stall");
        drive(0, 0, 3'd7, 1, 3'd7, 1, 1, 3'd2, 0, 0);
        step(ex(RUN, 0, 0, 8'h80), "invalid_reader_no_stall");
        idle();
        step(ex(RUN, 0, 0, 8'h00), "invalid_no_load");

        // Re-issue to r4 while cnt[4]=1 reloads the full latency.
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd4, 0, 0);
        step(ex(RUN, 0, 0, 8'h00), "add_r4_issue");
        idle();
        step(ex(RUN, 0, 0, 8'h10), "r4_cnt2");
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd4, 0, 0);
        step(ex(RUN, 0, 0, 8'h10), "r4_reissue_cnt1");
        drive(1, 0, 3'd0, 0, 3'd4, 1, 0, 3'd0, 0, 0);
        step(ex(RUN, 1, 0, 8'h10), "r4_reload_a");
        step(ex(RUN, 1, 0, 8'h10), "r4_reload_b");
        step(ex(RUN, 0, 0, 8'h00), "r4_release");
        idle();
`endif

        // HALT with nothing pending: stall from t+1, halted from t+4, held.
        drive(1, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1);
        step(ex(RUN, 0, 0, 8'h00), "halt_issue");
        idle();
        step(ex(DRAIN, 1, 0, 8'h00), "drain_t1");
        step(ex(DRAIN, 1, 0, 8'h00), "drain_t2");
        step(ex(DRAIN, 1, 0, 8'h00), "drain_t3");
        step(ex(HALTED, 1, 1, 8'h00), "halted_t4");
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd1, 0, 0);
        step(ex(HALTED, 1, 1, 8'h00), "halted_hold_a");
        idle();
        step(ex(HALTED, 1, 1, 8'h00), "halted_no_issue");

        // Reset out of HALTED.
        rst = 1'b1;
        #2;
        exp_q.push_back(ex(RUN, 0, 0, 8'h00));
        compare("reset_from_halted");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-DRAIN with two writes pending.
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd1, 1, 0);
        step(ex(RUN, 0, 0, 8'h00), "ld_r1_issue");
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd2, 1, 1);
        step(ex(RUN, 0, 0, 8'h02), "halt_wr_issue");
        idle();
        exp_q.push_back(ex(DRAIN, 1, 0, MID_DRAIN_BUSY));
        @(negedge clk);
        compare("mid_drain");
        #1;
        rst = 1'b1;
        #1;
        exp_q.push_back(ex(RUN, 0, 0, 8'h00));
        compare("async_reset_mid_drain");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(ex(RUN, 0, 0, 8'h00), "post_reset_idle");

        // Normal operation resumes after reset.
        drive(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd1, 1, 0);
        step(ex(RUN, 0, 0, 8'h00), "resume_issue");
        idle();
        step(ex(RUN, 0, 0, 8'h02), "resume_busy");

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
